// File: rtl/vm_pkg.sv
// Shared denominations, coin values and sequencer states for the vending datapath.
package vm_pkg;

    localparam int NUM_DENOM = 5;

    localparam int NICKEL  = 0;
    localparam int DIME    = 1;
    localparam int QUARTER = 2;
    localparam int FIFTY   = 3;
    localparam int DOLLAR  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        FINISH,
        CHECK
    } seqState_t;

    function automatic logic [6:0] coinValue(logic [2:0] d);
        case (d)
            3'd0:    coinValue = 7'd5;
            3'd1:    coinValue = 7'd10;
            3'd2:    coinValue = 7'd25;
            3'd3:    coinValue = 7'd50;
            3'd4:    coinValue = 7'd100;
            default: coinValue = 7'd0;
        endcase
    endfunction

    // Highest set bit wins, so the largest usable coin is chosen
    function automatic logic [2:0] pickLargest(logic [NUM_DENOM-1:0] avail);
        pickLargest = 3'd0;
        for (int d = 0; d < NUM_DENOM; d++) begin
            if (avail[d]) pickLargest = 3'(d);
        end
    endfunction

    function automatic logic [NUM_DENOM-1:0] oneHot(logic [2:0] d);
        oneHot = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (3'(i) == d) oneHot[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Five saturating per-denomination coin counters with increment and decrement.
module coin_inventory
    import vm_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int INIT_COUNT = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_DENOM-1:0]       inc,
    input  logic [NUM_DENOM-1:0]       dec,
    output logic [NUM_DENOM*CNT_W-1:0] counts
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_COUNT);

    logic [CNT_W-1:0] cnt [NUM_DENOM];

    // A coin arriving while the same coin leaves cancels out
    always_ff @(posedge clk) begin
        for (int d = 0; d < NUM_DENOM; d++) begin
            if (reset) begin
                cnt[d] <= CNT_INIT;
            end else if (inc[d] && !dec[d] && cnt[d] != CNT_MAX) begin
                cnt[d] <= cnt[d] + 1'b1;
            end else if (dec[d] && !inc[d] && cnt[d] != '0) begin
                cnt[d] <= cnt[d] - 1'b1;
            end
        end
    end

    always_comb begin
        counts = '0;
        for (int d = 0; d < NUM_DENOM; d++) begin
            counts[d*CNT_W +: CNT_W] = cnt[d];
        end
    end

endmodule

// File: rtl/change_sequencer.sv
// Greedy change payout through the coin hopper with per-coin ack and timeout.
// Optional EXACT_CHANGE_CHECK_EN adds a dry-run CHECK pass and exactChangeOnly.
module change_sequencer
    import vm_pkg::*;
#(
    parameter int AMT_W       = 14,
    parameter int CNT_W       = 8,
    parameter int INIT_COUNT  = 20,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_DENOM-1:0]       coinIn,
    input  logic                       start,
    input  logic [AMT_W-1:0]           amount,
    input  logic                       ejectAck,
    output logic [NUM_DENOM-1:0]       ejectCoin,
    output logic                       busy,
    output logic                       done,
    output logic [AMT_W-1:0]           shortfall,
    output logic                       fault,
    output logic [NUM_DENOM*CNT_W-1:0] invCount
`ifdef EXACT_CHANGE_CHECK_EN
    ,
    output logic                       exactChangeOnly
`endif
);

    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    seqState_t              state;
    seqState_t              nextState;
    logic [AMT_W-1:0]       rem;
    logic [TW-1:0]          timer;
    logic [2:0]             coinSel;
    logic [NUM_DENOM-1:0]   avail;
    logic [2:0]             pick;
    logic                   found;
    logic                   timeoutHit;
    logic [NUM_DENOM-1:0]   decVec;

    coin_inventory #(
        .CNT_W     (CNT_W),
        .INIT_COUNT(INIT_COUNT)
    ) inventory (
        .clk   (clk),
        .reset (reset),
        .inc   (coinIn),
        .dec   (decVec),
        .counts(invCount)
    );

    always_comb begin
        avail = '0;
        for (int d = 0; d < NUM_DENOM; d++) begin
            avail[d] = (invCount[d*CNT_W +: CNT_W] != '0)
                    && (AMT_W'(coinValue(3'(d))) <= rem);
        end
        found      = |avail;
        pick       = pickLargest(avail);
        timeoutHit = (timer == TW'(ACK_TIMEOUT - 1));
    end

`ifdef EXACT_CHANGE_CHECK_EN
    logic [AMT_W-1:0]     shRem;
    logic [CNT_W-1:0]     shCnt [NUM_DENOM];
    logic [NUM_DENOM-1:0] shAvail;
    logic [2:0]           shPick;

    always_comb begin
        shAvail = '0;
        for (int d = 0; d < NUM_DENOM; d++) begin
            shAvail[d] = (shCnt[d] != '0)
                      && (AMT_W'(coinValue(3'(d))) <= shRem);
        end
        shPick = pickLargest(shAvail);
    end

    // Shadow greedy run: same loop as the real payout, no hopper traffic
    always_ff @(posedge clk) begin
        if (reset) begin
            shRem           <= '0;
            exactChangeOnly <= 1'b0;
            for (int d = 0; d < NUM_DENOM; d++) shCnt[d] <= '0;
        end else if (state == IDLE && start) begin
            shRem <= amount;
            for (int d = 0; d < NUM_DENOM; d++) begin
                shCnt[d] <= invCount[d*CNT_W +: CNT_W];
            end
        end else if (state == CHECK) begin
            if (|shAvail) begin
                shRem         <= shRem - AMT_W'(coinValue(shPick));
                shCnt[shPick] <= shCnt[shPick] - 1'b1;
            end else begin
                exactChangeOnly <= (shRem != '0);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
`ifdef EXACT_CHANGE_CHECK_EN
                if (start) nextState = CHECK;
`else
                if (start) nextState = SELECT;
`endif
            end
            SELECT: nextState = found ? EJECT : FINISH;
            EJECT: begin
                if (ejectAck)        nextState = SELECT;
                else if (timeoutHit) nextState = FINISH;
            end
            FINISH: nextState = IDLE;
`ifdef EXACT_CHANGE_CHECK_EN
            CHECK: begin
                if (|shAvail)          nextState = CHECK;
                else if (shRem == '0)  nextState = SELECT;
                else                   nextState = FINISH;
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        decVec = (state == EJECT && ejectAck) ? ejectCoin : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem       <= '0;
            timer     <= '0;
            coinSel   <= '0;
            ejectCoin <= '0;
            done      <= 1'b0;
            shortfall <= '0;
            fault     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem       <= amount;
                        fault     <= 1'b0;
                        shortfall <= '0;
                    end
                end
                SELECT: begin
                    if (found) begin
                        ejectCoin <= oneHot(pick);
                        coinSel   <= pick;
                        timer     <= '0;
                    end
                end
                EJECT: begin
                    if (ejectAck) begin
                        rem       <= rem - AMT_W'(coinValue(coinSel));
                        ejectCoin <= '0;
                    end else if (timeoutHit) begin
                        fault     <= 1'b1;
                        ejectCoin <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FINISH: begin
                    shortfall <= rem;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/change_sequencer.md
Name: change_sequencer

Overview:
- Pays out change after a vend or a cancelReset.
- Owns the coin inventory of the machine: five denominations, each a saturating counter.
- On a start request it drives the shared coin-eject mechanism one coin at a time, using a greedy algorithm limited by inventory, with a per-coin ack handshake and timeout.
- Sits between vending_machine (which supplies the refund amount) and the hopper actuator.

Parameters:
- AMT_W, 14, width of amount/shortfall in cents.
- CNT_W, 8, width of each inventory counter.
- INIT_COUNT, 20, per-denomination count loaded at reset.
- ACK_TIMEOUT, 1000, cycles to wait for ejectAck before faulting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- coinIn  in  5  one-cycle pulses, coin accepted. Index 0 nickel, 1 dime, 2 quarter, 3 fifty, 4 dollar.
- start  in  1  pulse: begin payout of amount.
- amount  in  AMT_W  refund in cents, sampled with start.
- ejectAck  in  1  hopper pulse: requested coin has left.
- ejectCoin  out  5  one-hot level; held until ack or timeout.
- busy  out  1  payout in progress.
- done  out  1  one-cycle pulse at payout end.
- shortfall  out  AMT_W  cents not paid out; valid from done until next start.
- fault  out  1  ack timeout occurred; sticky until next accepted start.
- invCount  out  5*CNT_W  flattened counters, nickel in the LSBs.

Behaviour:
- Reset (sync, active-high, clk):
  - State IDLE.
  - All outputs 0.
  - Every counter = INIT_COUNT.
  - Reset mid-payout aborts it immediately; no done pulse.
- States: IDLE, SELECT, EJECT, FINISH.
- IDLE:
  - start latches amount into rem, clears fault and shortfall, goes to SELECT. busy=1 from the next cycle.
  - start while not IDLE is ignored.
- SELECT (1 cycle):
  - Pick the largest denomination d with value(d) ≤ rem and count(d) > 0.
  - If found: go to EJECT, register ejectCoin = onehot(d), clear the timeout counter.
  - Else: go to FINISH.
  - First ejectCoin is high 2 cycles after the start cycle.
- EJECT:
  - On ejectAck: rem -= value(d), count(d) -= 1, ejectCoin = 0, go to SELECT.
  - If the timeout counter reaches ACK_TIMEOUT: fault=1, ejectCoin=0, no decrement, go to FINISH.
  - ejectAck outside EJECT is ignored.
- FINISH (1 cycle): shortfall = rem, done=1, busy=0 next cycle, go to IDLE.
- amount=0: no ejects; done 3 cycles after start; shortfall=0.
- Amounts not a multiple of 5 leave remainder 1–4 as shortfall.
- Inventory:
  - coinIn increments the matching counter in every state, saturating at 2^CNT_W−1.
  - coinIn and eject decrement on the same denomination in the same cycle: net no change.
  - Decrement never occurs at 0, since SELECT guarantees count > 0.
- Arithmetic: unsigned. Values table 5/10/25/50/100, zero-extended to AMT_W.

Optional Feature:
- Macro: EXACT_CHANGE_CHECK_EN.
- With the macro:
  - Extra state CHECK between IDLE and SELECT.
  - CHECK runs the same greedy loop on shadow copies of rem and the counts, one coin per cycle, with no ejects.
  - If the shadow remainder is ≠ 0: no coins ejected, shortfall = amount, done pulses, output exactChangeOnly (1 bit, reset 0) goes to 1.
  - exactChangeOnly clears on the next fully satisfiable check.
  - If the shadow remainder is 0: normal payout proceeds.
- Without the macro: no CHECK state, no exactChangeOnly port; partial payout with shortfall.

Decomposition:
- Shared package vm_pkg:
  - Denomination index constants (NICKEL=0..DOLLAR=4).
  - NUM_DENOM=5.
  - Coin value table.
  - State enum.
- Sub-module coin_inventory:
  - Five saturating CNT_W counters, each with inc/dec.
  - Reset load of INIT_COUNT.
  - Flattened count output.

Test Plan:
- Default params, amount=65, ack 3 cycles after each eject → ejects fifty, dime, nickel in order; done, shortfall=0; counts 19/19/20/19/20.
- INIT_COUNT=1, amount=200 → dollar, fifty, quarter, dime, nickel ejected; shortfall=10; all counts 0.
- ACK_TIMEOUT=16, amount=25, ejectAck never asserted → ejectCoin[2] high 16 cycles, then fault=1, shortfall=25, quarter count unchanged at 20.
- coinIn[2] pulsed in the same cycle as the ack for a quarter eject → quarter count unchanged; pulse at count 255 with no eject → stays 255.
- start with amount=0 → no ejects, done 3 cycles later; second start while busy → ignored; reset during EJECT → ejectCoin=0, busy=0, counts=INIT_COUNT, no done.
- EXACT_CHANGE_CHECK_EN, INIT_COUNT=1, amount=200 → zero ejects, exactChangeOnly=1, shortfall=200; then amount=15 → nickel+dime paid, exactChangeOnly=0.
